// File: rtl/alu_unit.sv
// Registered RV32I execute unit: decodes Opcode/FuncCode into an ALU control word,
// computes the result and branch condition, and registers both for the EX/MEM stage.
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      Opcode,
  input  logic [3:0]      FuncCode,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [6:0]      ALUCtl,
  output logic [XLEN-1:0] ALUOut,
  output logic            Branch_Enable
);

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_PASSB = 4'b1001;
  localparam logic [3:0] OP_ZERO  = 4'b1110;
  localparam logic [3:0] OP_SLTU  = 4'b1111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  // Shared R/I-type table; 'alt' is instr[30] already qualified by the caller.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic [2:0] f3;
  logic       f7b;
  logic [3:0] alu_op;
  logic [2:0] br_cond;

  assign f3  = FuncCode[2:0];
  assign f7b = FuncCode[3];

  always_comb begin
    alu_op  = OP_ZERO;
    br_cond = BR_NONE;
    case (Opcode)
      OPC_RTYPE: alu_op = arith_op(f3, f7b);
      // Immediates reuse instr[30] as data except for the shift-right pair.
      OPC_ITYPE: alu_op = arith_op(f3, f7b && (f3 == 3'b101));
      OPC_LUI:   alu_op = OP_PASSB;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: alu_op = OP_ADD;
      OPC_BRANCH: begin
        alu_op = OP_SUB;
        case (f3)
          3'b000:  br_cond = BR_BEQ;
          3'b001:  br_cond = BR_BNE;
          3'b100:  br_cond = BR_BLT;
          3'b101:  br_cond = BR_BGE;
          3'b110:  br_cond = BR_BLTU;
          3'b111:  br_cond = BR_BGEU;
          default: br_cond = BR_NONE;
        endcase
      end
      default: begin
        alu_op  = OP_ZERO;
        br_cond = BR_NONE;
      end
    endcase
  end

  assign ALUCtl = {br_cond, alu_op};

  logic [4:0]      shamt;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            equal;
  logic [XLEN-1:0] result;
  logic            taken;

  assign shamt       = B[4:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;
  assign equal       = (A == B);

  always_comb begin
    result = '0;
    case (alu_op)
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_XOR:   result = A ^ B;
      OP_ADD:   result = A + B;
      OP_SUB:   result = A - B;
      OP_SLL:   result = A << shamt;
      OP_SRL:   result = A >> shamt;
      OP_SRA:   result = $unsigned($signed(A) >>> shamt);
      OP_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_PASSB: result = B;
      default:  result = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (br_cond)
      BR_BEQ:  taken = equal;
      BR_BNE:  taken = !equal;
      BR_BLT:  taken = lt_signed;
      BR_BGE:  taken = !lt_signed;
      BR_BLTU: taken = lt_unsigned;
      BR_BGEU: taken = !lt_unsigned;
      default: taken = 1'b0;
    endcase
  end

  // No handshake: every cycle's operands are accepted and their result is
  // visible exactly one edge later; reset overrides that cycle's operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut        <= '0;
      Branch_Enable <= 1'b0;
    end else begin
      ALUOut        <= result;
      Branch_Enable <= taken;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed steps from the test plan, then random traffic
// checked one cycle later against an arithmetic reference model.
module tb_alu_unit;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [3:0]  func_code;
  logic [31:0] a;
  logic [31:0] b;
  logic [6:0]  alu_ctl;
  logic [31:0] alu_out;
  logic        branch_enable;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        exp_br_q[$];

  alu_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .Opcode        (opcode),
    .FuncCode      (func_code),
    .A             (a),
    .B             (b),
    .ALUCtl        (alu_ctl),
    .ALUOut        (alu_out),
    .Branch_Enable (branch_enable)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model computed from the ISA rules directly.
  function automatic void ref_model(input logic [6:0] opc, input logic [3:0] fc,
                                    input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] res, output logic br);
    int          s;
    logic [2:0]  f3;
    logic        alt;
    longint      sx;
    longint      sy;
    f3  = fc[2:0];
    alt = fc[3];
    s   = int'(y[4:0]);
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = 32'd0;
    br  = 1'b0;
    if (opc == R_OP || opc == I_OP) begin
      if (opc == I_OP && f3 != 3'd5) alt = 1'b0;
      case (f3)
        3'd0: res = alt ? x - y : x + y;
        3'd1: res = x << s;
        3'd2: res = (sx < sy) ? 32'd1 : 32'd0;
        3'd3: res = (x < y) ? 32'd1 : 32'd0;
        3'd4: res = x ^ y;
        3'd5: res = (x >> s) | ((alt && x[31]) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
        3'd6: res = x | y;
        default: res = x & y;
      endcase
    end else if (opc == LUI) begin
      res = y;
    end else if (opc == AUIPC || opc == JAL || opc == JALR || opc == LOAD || opc == STORE) begin
      res = x + y;
    end else if (opc == BR_OP) begin
      res = x - y;
      case (f3)
        3'd0: br = (x == y);
        3'd1: br = (x != y);
        3'd4: br = (sx < sy);
        3'd5: br = (sx >= sy);
        3'd6: br = (x < y);
        3'd7: br = (x >= y);
        default: br = 1'b0;
      endcase
    end
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: one op per cycle, scored on the following edge.
  task automatic step(input string tag, input logic rst, input logic [6:0] opc,
                      input logic [3:0] fc, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        bt;
    @(negedge clk);
    reset     = rst;
    opcode    = opc;
    func_code = fc;
    a         = x;
    b         = y;
    ref_model(opc, fc, x, y, r, bt);
    if (rst) begin
      r  = 32'd0;
      bt = 1'b0;
    end
    exp_q.push_back(r);
    exp_br_q.push_back(bt);
    @(posedge clk);
    #1;
    check32({tag, ".out"}, alu_out, exp_q.pop_front());
    check32({tag, ".br"}, {31'd0, branch_enable}, {31'd0, exp_br_q.pop_front()});
  endtask

  initial begin
    logic [6:0] opc_tbl [0:10];
    logic [6:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;
    opc_tbl = '{R_OP, I_OP, LUI, AUIPC, JAL, JALR, LOAD, STORE, BR_OP, 7'b1111111, 7'b0001111};
    reset = 1'b1;
    opcode = R_OP;
    func_code = 4'b0111;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;

    step("rst0", 1'b1, R_OP, 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check32("ctl_in_reset", {25'd0, alu_ctl}, 32'h0000_0000);
    step("rst1", 1'b1, R_OP, 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("rel",  1'b0, R_OP, 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    step("and",   1'b0, R_OP, 4'b0111, 32'h0F, 32'h55);
    step("or",    1'b0, R_OP, 4'b0110, 32'h0F, 32'h55);
    step("xor",   1'b0, R_OP, 4'b0100, 32'h55, 32'hFF);
    step("add",   1'b0, R_OP, 4'b0000, 32'd10000, 32'd111);
    step("sub",   1'b0, R_OP, 4'b1000, 32'd10000, 32'd111);
    step("subw",  1'b0, R_OP, 4'b1000, 32'd0, 32'd1);
    step("slt",   1'b0, R_OP, 4'b0010, 32'd0, 32'd2);
    step("sltn",  1'b0, R_OP, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    step("sltu",  1'b0, R_OP, 4'b0011, 32'hFFFF_FFFF, 32'd1);
    step("srl",   1'b0, R_OP, 4'b0101, 32'd16, 32'd2);
    step("sra",   1'b0, R_OP, 4'b1101, 32'd8, 32'd1);
    step("sran",  1'b0, R_OP, 4'b1101, 32'h8000_0000, 32'd4);
    step("sll",   1'b0, R_OP, 4'b0001, 32'd2, 32'd2);
    step("sllm",  1'b0, R_OP, 4'b0001, 32'd2, 32'h22);
    step("addi",  1'b0, I_OP, 4'b1000, 32'd5, 32'd3);
    step("lui",   1'b0, LUI,  4'b0000, 32'd77, 32'h1234_5000);
    step("bad",   1'b0, 7'b1111111, 4'b0000, 32'd9, 32'd4);
    check32("ctl_bad", {25'd0, alu_ctl}, {25'd0, 7'b000_1110});
    step("beq",   1'b0, BR_OP, 4'b0000, 32'd7, 32'd7);
    step("bne",   1'b0, BR_OP, 4'b0001, 32'd7, 32'd7);
    step("blt",   1'b0, BR_OP, 4'b0100, 32'hFFFF_FFFF, 32'd1);
    step("bltu",  1'b0, BR_OP, 4'b0110, 32'hFFFF_FFFF, 32'd1);
    check32("ctl_bltu", {25'd0, alu_ctl}, {25'd0, 7'b101_0110});
    step("bge",   1'b0, BR_OP, 4'b0101, 32'd42, 32'd42);
    step("bf3_2", 1'b0, BR_OP, 4'b0010, 32'd3, 32'd3);
    step("rst_mid", 1'b1, R_OP, 4'b0000, 32'd1, 32'd2);

    // Random back-to-back traffic; equal operands are forced often to hit BEQ/BGE edges.
    for (int i = 0; i < 300; i++) begin
      ro = opc_tbl[$urandom_range(0, 10)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 4) == 0) rb = {27'd0, 5'($urandom_range(0, 31))};
      step("rand", ($urandom_range(0, 49) == 0), ro, 4'($urandom_range(0, 15)), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered RV32I integer execute block for the sail-core datapath.
- Decodes Opcode plus FuncCode ({instr[30], instr[14:12]}) into a 7-bit ALU control word.
- Executes the operation on operands A/B and produces the ALU result and a branch-taken flag.
- Sits between the ID/EX operand muxes and the EX/MEM stage.

Parameters:
- XLEN, 32, datapath width (only 32 supported; shift amount is B[4:0]).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- Opcode  input  7  instr[6:0]
- FuncCode  input  4  {instr[30], instr[14:12]}
- A  input  32  operand A (rs1/PC)
- B  input  32  operand B (rs2/immediate)
- ALUCtl  output  7  combinational decoded control word (debug/observability)
- ALUOut  output  32  registered result
- Branch_Enable  output  1  registered branch-taken flag

Behaviour:
- One clock; reset is synchronous and active-high. Reset clears ALUOut=0 and Branch_Enable=0 on the clock edge where reset=1; reset has priority over new operands. Operands present in a reset cycle are discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on ALUOut/Branch_Enable after edge N. Throughput is 1 op/cycle, with no handshake.
- ALUCtl[3:0] operation encoding:
  - AND=0000, OR=0001, ADD=0010, SLL=0101, SRL=0011, SRA=0100
  - SUB=0110, SLT=0111, SLTU=1111, XOR=1000
  - PASSB=1001, ZERO=1110
- ALUCtl[6:4] branch condition encoding:
  - NONE=000, BEQ=001, BNE=010, BLT=011, BGE=100, BLTU=101, BGEU=110
- Decode for R-type (0110011), f3 = FuncCode[2:0], f7b = FuncCode[3]:
  - 000: ADD, or SUB if f7b=1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA if f7b=1
  - 110: OR
  - 111: AND
- Decode for I-type ALU (0010011): same table, but f7b is honoured only for f3=101. ADDI with f7b=1 is ADD.
- LUI (0110111): PASSB.
- AUIPC (0010111), JAL (1101111), JALR (1100111), LOAD (0000011), STORE (0100011): ADD.
- BRANCH (1100011): op=SUB. f3 000/001/100/101/110/111 maps to BEQ/BNE/BLT/BGE/BLTU/BGEU. f3 010/011 maps to NONE.
- Any other opcode: op=ZERO, branch=NONE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32, with no overflow flag.
  - SLT compares signed; SLTU compares unsigned. Both produce 32'd1 or 32'd0.
  - Shifts use B[4:0] only. SRA replicates A[31].
  - PASSB yields B; ZERO yields 0.
- Branch_Enable is computed from A,B per branch field:
  - BEQ: A==B; BNE: A!=B
  - BLT/BGE: signed <, >=
  - BLTU/BGEU: unsigned <, >=
  - NONE: 0. Branch_Enable is 0 for every non-branch opcode.
- ALUCtl is purely combinational from Opcode/FuncCode and is unaffected by reset.

Test Plan:
- Reset: assert reset for 2 cycles with A=B=FFFFFFFF, R-type AND -> ALUOut=0, Branch_Enable=0; release -> next cycle ALUOut=FFFFFFFF.
- R-type logic and arithmetic, with A, B, FuncCode under Opcode 0110011, ALUOut one cycle later:
  - AND: A=0x0F, B=0x55, FuncCode=0111 -> ALUOut=0x05
  - OR: A=0x0F, B=0x55, FuncCode=0110 -> 0x5F
  - XOR: A=0x55, B=0xFF, FuncCode=0100 -> 0xAA
  - ADD: A=10000, B=111, FuncCode=0000 -> 10111
  - SUB: A=10000, B=111, FuncCode=1000 -> 9889
  - SUB wrap: A=0, B=1, FuncCode=1000 -> FFFFFFFF
- Compare and shift, Opcode 0110011:
  - SLT: A=0, B=2, FuncCode=0010 -> 1
  - SLT vs SLTU: A=FFFFFFFF, B=1 -> SLT (FuncCode=0010) 1, SLTU (FuncCode=0011) 0
  - SRL: A=16, B=2, FuncCode=0101 -> 4
  - SRA: A=8, B=1, FuncCode=1101 -> 4; SRA A=80000000, B=4 -> F8000000
  - SLL: A=2, B=2, FuncCode=0001 -> 8; SLL B=0x22 -> shift by 2 only
- I-type and misc opcodes:
  - Opcode 0010011, FuncCode=1000, A=5, B=3 -> 8 (not SUB)
  - LUI with B=12345000 -> 12345000
  - Opcode 1111111 -> ALUOut=0, Branch_Enable=0
- Branches (Opcode 1100011):
  - BEQ A=B=7 -> Branch_Enable=1
  - BNE A=B=7 -> 0
  - BLT A=FFFFFFFF, B=1 -> 1
  - BLTU same operands -> 0
  - BGE A=B -> 1
  - f3=010 -> 0
- Back-to-back: change op every cycle -> each result appears exactly one cycle after its inputs, with no bubbles.
